dmem_store_buffer: RTL and testbench

- MEM-stage store buffer and data-memory port arbiter, directly upstream of the data memory.
- Queues stores from the pipeline and drains them into the memory's single write/address port in cycles with no load.
- Checks alignment, stalls on load/store word-address hazards and on fence.
- Presents store_sel/load_sel/address/data to the data memory; passes load data back.

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/stbuf_load_extract.sv | 27 ++
 rtl/dmem_store_buffer.sv | 151 +++++++++++++++
 tb/tb_dmem_store_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage store buffer: funct3 encodings, entry layout,
// and the alignment rule used for both loads and stores.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 3;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  sel;
    } stbuf_entry_t;

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_B, F3_BU: return 1'b0;
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return addr_lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stbuf_load_extract.sv
// Picks the byte/half/word addressed by a load out of a 32-bit word and sign- or
// zero-extends it according to funct3.
module stbuf_load_extract
    import dmem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = word[{offset, 3'b000} +: 8];
        half_val = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_val[7]}}, byte_val};
            F3_BU:   data = {24'h0, byte_val};
            F3_H:    data = {{16{half_val[15]}}, half_val};
            F3_HU:   data = {16'h0, half_val};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_store_buffer.sv
// MEM-stage store buffer and data-memory port arbiter. Loads own the port; queued stores
// drain in program order whenever the port is free. Define STBUF_FWD_EN to forward word stores.
module dmem_store_buffer
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid_M,
    input  logic        ld_valid_M,
    input  logic        fence_M,
    input  logic [2:0]  funct3_M,
    input  logic [31:0] addr_M,
    input  logic [31:0] wdata_M,
    output logic        stall_M,
    output logic        misalign_M,
    output logic [31:0] ld_data_M,
    output logic        dm_we,
    output logic [2:0]  dm_store_sel,
    output logic [2:0]  dm_load_sel,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic [31:0] dm_rdata
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    stbuf_entry_t     entries_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;

    logic             mis, ld_ok, st_ok, full, empty;
    logic             hit, fwd_hit, ld_serve, ld_fwd, ld_stall;
    logic             enq, drain;
    logic [PTR_W-1:0] scan_idx;
    logic [31:0]      fwd_data;
`ifdef STBUF_FWD_EN
    logic [PTR_W-1:0] young_idx;
`endif

    assign mis   = (st_valid_M | ld_valid_M) & misaligned(funct3_M, addr_M[1:0]);
    assign ld_ok = ld_valid_M & ~mis;
    assign st_ok = st_valid_M & ~ld_valid_M & ~mis;
    assign full  = count_q == FULL_CNT;
    assign empty = count_q == '0;

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        hit      = 1'b0;
        scan_idx = head_q;
`ifdef STBUF_FWD_EN
        young_idx = head_q;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = head_q + PTR_W'(k);
            if (((PTR_W+1)'(k) < count_q) && (entries_q[scan_idx].addr[31:2] == addr_M[31:2])) begin
                hit = 1'b1;
`ifdef STBUF_FWD_EN
                young_idx = scan_idx;
`endif
            end
        end
    end

`ifdef STBUF_FWD_EN
    assign fwd_hit = hit & (entries_q[young_idx].sel == F3_W);

    stbuf_load_extract u_extract (
        .word   (entries_q[young_idx].data),
        .funct3 (funct3_M),
        .offset (addr_M[1:0]),
        .data   (fwd_data)
    );
`else
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign ld_serve = ld_ok & ~hit;
    assign ld_fwd   = ld_ok & fwd_hit;
    assign ld_stall = ld_ok & hit & ~fwd_hit;

    assign stall_M    = ld_stall | (st_ok & full) | (fence_M & ~empty);
    assign misalign_M = mis;
    assign enq        = st_ok & ~full & ~stall_M;
    assign drain      = ~empty & ~ld_serve;

    always_comb begin
        dm_we        = 1'b0;
        dm_addr      = addr_M;
        dm_load_sel  = '0;
        dm_store_sel = '0;
        dm_wdata     = '0;
        ld_data_M    = '0;
        if (ld_serve) begin
            dm_load_sel = funct3_M;
            ld_data_M   = dm_rdata;
        end else if (drain) begin
            dm_we        = 1'b1;
            dm_addr      = entries_q[head_q].addr;
            dm_wdata     = entries_q[head_q].data;
            dm_store_sel = entries_q[head_q].sel;
        end
        if (ld_fwd) begin
            ld_data_M = fwd_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (drain) begin
            head_d = head_q + PTR_W'(1);
        end
        if (enq) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({enq, drain})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: validity is carried entirely by head/count.
    always_ff @(posedge clk) begin
        if (enq) begin
            entries_q[tail_q] <= '{addr: addr_M, data: wdata_M, sel: funct3_M};
        end
    end

    illegal_ld_st : assert property (@(posedge clk) disable iff (rst)
        !(st_valid_M && ld_valid_M));

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Randomized bench for dmem_store_buffer: an architectural store queue plus byte memory
// predicts stalls, drains and load results every cycle.
module tb_dmem_store_buffer;

    localparam int DEPTH = 4;
`ifdef STBUF_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk, rst;
    logic        st_valid_M, ld_valid_M, fence_M;
    logic [2:0]  funct3_M;
    logic [31:0] addr_M, wdata_M;
    logic        stall_M, misalign_M, dm_we;
    logic [31:0] ld_data_M, dm_addr, dm_wdata, dm_rdata;
    logic [2:0]  dm_store_sel, dm_load_sel;

    dmem_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .st_valid_M   (st_valid_M),
        .ld_valid_M   (ld_valid_M),
        .fence_M      (fence_M),
        .funct3_M     (funct3_M),
        .addr_M       (addr_M),
        .wdata_M      (wdata_M),
        .stall_M      (stall_M),
        .misalign_M   (misalign_M),
        .ld_data_M    (ld_data_M),
        .dm_we        (dm_we),
        .dm_store_sel (dm_store_sel),
        .dm_load_sel  (dm_load_sel),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .dm_rdata     (dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Load formatting as the memory would return it.
    function automatic logic [31:0] fmt(input logic [31:0] w, input logic [2:0] f3,
                                        input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (int'(off) * 8)) & 32'hFF;
        h = off[1] ? (w >> 16) : (w & 32'hFFFF);
        case (f3)
            3'b000:  return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'b001:  return h[15] ? (h | 32'hFFFF_0000) : h;
            3'b010:  return w;
            3'b100:  return b;
            3'b101:  return h & 32'hFFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b010) return (a % 4) != 0;
        if (f3 == 3'b001 || f3 == 3'b101) return (a % 2) != 0;
        return 1'b0;
    endfunction

    // Device memory: what has actually been written through the port.
    logic [7:0]  dev_mem  [1024] = '{default: 8'h00};
    logic [7:0]  arch_mem [1024] = '{default: 8'h00};
    logic [31:0] dev_word;

    always_comb begin
        dev_word = {dev_mem[{dm_addr[9:2], 2'd3}], dev_mem[{dm_addr[9:2], 2'd2}],
                    dev_mem[{dm_addr[9:2], 2'd1}], dev_mem[{dm_addr[9:2], 2'd0}]};
        dm_rdata = fmt(dev_word, dm_load_sel, dm_addr[1:0]);
    end

    always @(posedge clk) begin
        if (dm_we) begin
            case (dm_store_sel)
                3'b000: dev_mem[dm_addr[9:0]] <= dm_wdata[7:0];
                3'b001: begin
                    dev_mem[{dm_addr[9:1], 1'b0}] <= dm_wdata[7:0];
                    dev_mem[{dm_addr[9:1], 1'b1}] <= dm_wdata[15:8];
                end
                3'b010: begin
                    dev_mem[{dm_addr[9:2], 2'd0}] <= dm_wdata[7:0];
                    dev_mem[{dm_addr[9:2], 2'd1}] <= dm_wdata[15:8];
                    dev_mem[{dm_addr[9:2], 2'd2}] <= dm_wdata[23:16];
                    dev_mem[{dm_addr[9:2], 2'd3}] <= dm_wdata[31:24];
                end
                default: ;
            endcase
        end
    end

    // Reference: program-order store queue and architectural memory.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  sel;
    } st_t;
    st_t q[$];

    task automatic arch_write(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sel);
        int nb;
        int base;
        nb   = (sel == 3'b000) ? 1 : (sel == 3'b001) ? 2 : 4;
        base = int'(a[9:0]) & ~(nb - 1);
        for (int i = 0; i < nb; i++) arch_mem[base + i] = d[8*i +: 8];
    endtask

    function automatic logic [31:0] arch_word(input logic [31:0] a);
        int w;
        w = int'(a[9:0]) & ~3;
        return {arch_mem[w+3], arch_mem[w+2], arch_mem[w+1], arch_mem[w]};
    endfunction

    // One clock with the current inputs: predict, compare, then advance the model.
    task automatic run_cycle(output bit stalled);
        bit          mis, ld_ok, st_ok, hit, fwd, serve, drain, exp_stall, enq;
        logic [2:0]  ysel;
        logic [31:0] exp_ld;
        #1;
        mis   = (st_valid_M || ld_valid_M) && is_mis(funct3_M, addr_M);
        ld_ok = ld_valid_M && !mis;
        st_ok = st_valid_M && !ld_valid_M && !mis;
        hit   = 1'b0;
        ysel  = 3'b000;
        foreach (q[i]) begin
            if ((q[i].addr >> 2) == (addr_M >> 2)) begin
                hit  = 1'b1;
                ysel = q[i].sel;
            end
        end
        fwd       = FWD && ld_ok && hit && ysel == 3'b010;
        serve     = ld_ok && !hit;
        drain     = q.size() > 0 && !serve;
        exp_stall = (ld_ok && hit && !fwd) || (st_ok && q.size() == DEPTH)
                    || (fence_M && q.size() != 0);
        enq       = st_ok && q.size() < DEPTH && !exp_stall;
        exp_ld    = fmt(arch_word(addr_M), funct3_M, addr_M[1:0]);

        check("stall_M", 32'(stall_M), 32'(exp_stall));
        check("misalign_M", 32'(misalign_M), 32'(mis));
        check("dm_we", 32'(dm_we), 32'(drain));
        if (drain) begin
            check("drain_addr", dm_addr, q[0].addr);
            check("drain_wdata", dm_wdata, q[0].data);
            check("drain_sel", 32'(dm_store_sel), 32'(q[0].sel));
        end
        if (serve) begin
            check("ld_addr", dm_addr, addr_M);
            check("ld_data", ld_data_M, exp_ld);
        end
        if (fwd) check("fwd_data", ld_data_M, exp_ld);
        if (ld_valid_M && mis) check("mis_ld_data", ld_data_M, 32'h0);

        @(posedge clk);
        if (drain) void'(q.pop_front());
        if (enq) begin
            q.push_back('{addr: addr_M, data: wdata_M, sel: funct3_M});
            arch_write(addr_M, wdata_M, funct3_M);
        end
        @(negedge clk);
        stalled = exp_stall;
    endtask

    // Present one instruction and hold it while the block stalls.
    task automatic issue(input bit st, input bit ld, input bit fn, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bit s;
        int guard;
        st_valid_M = st;
        ld_valid_M = ld;
        fence_M    = fn;
        funct3_M   = f3;
        addr_M     = a;
        wdata_M    = d;
        guard      = 0;
        do begin
            run_cycle(s);
            guard++;
        end while (s && guard < 50);
        if (s) check("stall_bound", 32'(s), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, 3'b000, $urandom, 32'h0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        st_valid_M = 1'b0;
        ld_valid_M = 1'b0;
        fence_M    = 1'b0;
        funct3_M   = 3'b000;
        addr_M     = $urandom;
        #1;
        check("rst_dm_we", 32'(dm_we), 32'h0);
        check("rst_stall", 32'(stall_M), 32'h0);
        check("rst_store_sel", 32'(dm_store_sel), 32'h0);
        check("rst_dm_addr", dm_addr, addr_M);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        // Discarded stores never reach memory, so the architecture now matches the device.
        arch_mem = dev_mem;
    endtask

    logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        rst        = 1'b1;
        st_valid_M = 1'b0;
        ld_valid_M = 1'b0;
        fence_M    = 1'b0;
        funct3_M   = 3'b000;
        addr_M     = 32'h0;
        wdata_M    = 32'h0;
        @(negedge clk);
        do_reset();

        issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h10, 32'hDEAD_BEEF);
        idle(2);
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h80 + 4 * i, $urandom);
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
        idle(6);
        issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h21, 32'h0000_007F);
        issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h13, 32'h0);
        issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h22, 32'h1234_5678);
        for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h100 + 4 * i, $urandom);
        issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0);
        issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h40, 32'h8000_FF80);
        issue(1'b0, 1'b1, 1'b0, 3'b000, 32'h40, 32'h0);
        issue(1'b0, 1'b1, 1'b0, 3'b101, 32'h42, 32'h0);
        idle(6);

        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 1) == 0) a = {22'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            else a = {22'h0, 8'($urandom_range(0, 255)), 2'($urandom)};
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else if (r <= 3) begin
                issue(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 2)), a, $urandom);
            end else if (r <= 6) begin
                issue(1'b0, 1'b1, 1'b0, ld_f3[$urandom_range(0, 4)], a, 32'h0);
            end else if (r == 7) begin
                issue(1'b0, 1'b0, 1'b1, 3'b000, a, 32'h0);
            end else begin
                idle(1);
            end
        end
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
